// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the modulo up/down counter family.
// Holds the mode encoding, a width helper for the prescaler and the MODULUS legality check.
package counter_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
   function automatic int clog2(input int value);
      int w;
      int v;
      w = 0;
      v = value - 1;
      while (v > 0) begin
         w++;
         v = v >>> 1;
      end
      return w;
   endfunction

   function automatic bit modulus_ok(input int width, input int modulus);
      return (width >= 1) && (modulus >= 2) &&
             (longint'(modulus) <= (longint'(1) << width));
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: passes one en_in pulse out of every PRESCALE, cleared by clr.
// Only instantiated by counter_mod_updown when COUNTER_MOD_PRESCALE_EN is defined.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en_in,
   output logic en_out
);

   localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("counter_prescaler: PRESCALE must be >= 1");
   end

   logic [PW-1:0] pre;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pre <= '0;
      else if (clr)
         pre <= '0;
      else if (en_in)
         pre <= (pre == LAST) ? '0 : pre + 1'b1;
   end

   assign en_out = en_in & (pre == LAST);

endmodule

// File: rtl/counter_mod_updown.sv
// Parametrised up/down modulo counter with wrap/saturate, terminal count and sticky overflow.
// Define COUNTER_MOD_PRESCALE_EN to add a PRESCALE parameter that divides the count enable.
module counter_mod_updown
   import counter_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 2**WIDTH,
   parameter int SATURATE = CNT_WRAP
`ifdef COUNTER_MOD_PRESCALE_EN
   ,
   parameter int PRESCALE = 4
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             set,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   localparam bit SAT_MODE = (SATURATE == CNT_SAT);

   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("counter_mod_updown: MODULUS must lie in 2..2**WIDTH");
   end

   logic             step_en;
   logic             at_max;
   logic             at_zero;
   logic             boundary;
   logic             load_oor;
   logic [WIDTH-1:0] count_nxt;

`ifdef COUNTER_MOD_PRESCALE_EN
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clr    (set | load),
      .en_in  (en),
      .en_out (step_en)
   );
`else
   assign step_en = en;
`endif

   // A full-range modulus can never see an out-of-range load value.
   if (MODULUS < 2**WIDTH) begin : g_load_check
      assign load_oor = (load_value > MAX);
   end else begin : g_load_full
      assign load_oor = 1'b0;
   end

   assign at_max   = (count == MAX);
   assign at_zero  = (count == '0);
   assign tc       = step_en & ((up & at_max) | (~up & at_zero));
   assign boundary = tc & ~set & ~load;

   // NOTE: count_nxt gets its default first so no path through the block can infer a latch.
   always_comb begin
      count_nxt = count;
      if (set)
         count_nxt = MAX;
      else if (load)
         count_nxt = load_oor ? MAX : load_value;
      else if (step_en) begin
         if (up)
            count_nxt = at_max ? (SAT_MODE ? MAX : '0) : count + 1'b1;
         else
            count_nxt = at_zero ? (SAT_MODE ? '0 : MAX) : count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         wrap     <= 1'b0;
         ovf      <= 1'b0;
         load_err <= 1'b0;
      end else begin
         count    <= count_nxt;
         wrap     <= boundary;
         load_err <= load & ~set & load_oor;
         if (set | load)
            ovf <= 1'b0;
         else if (boundary)
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench for counter_mod_updown: WIDTH=3, MODULUS=6 in wrap and saturate modes.
// Expected values come from vector tables and flow through a scoreboard queue.
module tb_counter_mod_updown;

`ifdef COUNTER_MOD_PRESCALE_EN
   localparam int NDUT = 3;
`else
   localparam int NDUT = 2;
`endif

   typedef struct {
      logic       en;
      logic       up;
      logic       set;
      logic       load;
      logic [2:0] lv;
      logic       tc;
      logic [2:0] cnt;
      logic       wrap;
      logic       ovf;
      logic       lerr;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       en_s   [NDUT];
   logic       up_s   [NDUT];
   logic       set_s  [NDUT];
   logic       load_s [NDUT];
   logic [2:0] lv_s   [NDUT];
   logic [2:0] count_s[NDUT];
   logic       tc_s   [NDUT];
   logic       wrap_s [NDUT];
   logic       ovf_s  [NDUT];
   logic       lerr_s [NDUT];

   int total = 0;
   int bad   = 0;
   vec_t sb[$];
   vec_t tab_wrap[$];
   vec_t tab_sat[$];

   always #5 clk = ~clk;

   counter_mod_updown #(
      .WIDTH(3), .MODULUS(6), .SATURATE(0)
`ifdef COUNTER_MOD_PRESCALE_EN
      , .PRESCALE(1)
`endif
   ) u_dut_wrap (
      .clk(clk), .reset(reset), .en(en_s[0]), .up(up_s[0]), .set(set_s[0]),
      .load(load_s[0]), .load_value(lv_s[0]), .count(count_s[0]), .tc(tc_s[0]),
      .wrap(wrap_s[0]), .ovf(ovf_s[0]), .load_err(lerr_s[0])
   );

   counter_mod_updown #(
      .WIDTH(3), .MODULUS(6), .SATURATE(1)
`ifdef COUNTER_MOD_PRESCALE_EN
      , .PRESCALE(1)
`endif
   ) u_dut_sat (
      .clk(clk), .reset(reset), .en(en_s[1]), .up(up_s[1]), .set(set_s[1]),
      .load(load_s[1]), .load_value(lv_s[1]), .count(count_s[1]), .tc(tc_s[1]),
      .wrap(wrap_s[1]), .ovf(ovf_s[1]), .load_err(lerr_s[1])
   );

`ifdef COUNTER_MOD_PRESCALE_EN
   counter_mod_updown #(
      .WIDTH(3), .MODULUS(6), .SATURATE(0), .PRESCALE(4)
   ) u_dut_pre (
      .clk(clk), .reset(reset), .en(en_s[2]), .up(up_s[2]), .set(set_s[2]),
      .load(load_s[2]), .load_value(lv_s[2]), .count(count_s[2]), .tc(tc_s[2]),
      .wrap(wrap_s[2]), .ovf(ovf_s[2]), .load_err(lerr_s[2])
   );
`endif

   function automatic vec_t mk(input bit en, input bit up, input bit set, input bit load,
                               input int lv, input bit tc, input int cnt, input bit w,
                               input bit o, input bit le);
      vec_t v;
      v.en = en; v.up = up; v.set = set; v.load = load; v.lv = 3'(lv);
      v.tc = tc; v.cnt = 3'(cnt); v.wrap = w; v.ovf = o; v.lerr = le;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle();
      for (int d = 0; d < NDUT; d++) begin
         en_s[d] = 1'b0; up_s[d] = 1'b0; set_s[d] = 1'b0; load_s[d] = 1'b0; lv_s[d] = '0;
      end
   endtask

   // Drive one vector on the falling edge, check tc before the rising edge,
   // queue the registered expectations and compare them just after the edge.
   task automatic step(input int sel, input vec_t v, input string tag, input int idx);
      vec_t e;
      @(negedge clk);
      idle();
      en_s[sel] = v.en; up_s[sel] = v.up; set_s[sel] = v.set;
      load_s[sel] = v.load; lv_s[sel] = v.lv;
      #1;
      check($sformatf("%s[%0d] tc", tag, idx), 32'(tc_s[sel]), 32'(v.tc));
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("%s[%0d] count", tag, idx), 32'(count_s[sel]), 32'(e.cnt));
      check($sformatf("%s[%0d] wrap", tag, idx), 32'(wrap_s[sel]), 32'(e.wrap));
      check($sformatf("%s[%0d] ovf", tag, idx), 32'(ovf_s[sel]), 32'(e.ovf));
      check($sformatf("%s[%0d] load_err", tag, idx), 32'(lerr_s[sel]), 32'(e.lerr));
   endtask

   task automatic mid_cycle_reset(input string tag);
      #3;
      reset = 1'b1;
      idle();
      #1;
      check({tag, " count"}, 32'(count_s[0]), 32'd0);
      check({tag, " ovf"}, 32'(ovf_s[0]), 32'd0);
      check({tag, " wrap"}, 32'(wrap_s[0]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      // Wrap mode (en, up, set, load, lv | tc, count, wrap, ovf, load_err)
      tab_wrap.push_back(mk(0,0,0,1,0, 0,0,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,1,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,2,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,3,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,4,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,5,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 1,0,1,1,0));
      tab_wrap.push_back(mk(0,1,0,0,0, 0,0,0,1,0));
      tab_wrap.push_back(mk(1,0,0,0,0, 1,5,1,1,0));
      tab_wrap.push_back(mk(0,0,0,1,3, 0,3,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,4,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,5,0,0,0));
      tab_wrap.push_back(mk(1,1,1,1,2, 1,5,0,0,0));
      tab_wrap.push_back(mk(0,0,0,1,2, 0,2,0,0,0));
      tab_wrap.push_back(mk(0,0,0,1,7, 0,5,0,0,1));
      tab_wrap.push_back(mk(0,0,0,0,0, 0,5,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 1,0,1,1,0));
      tab_wrap.push_back(mk(1,0,0,0,0, 1,5,1,1,0));
      tab_wrap.push_back(mk(1,0,0,0,0, 0,4,0,1,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 0,5,0,1,0));
      tab_wrap.push_back(mk(1,1,0,1,5, 1,5,0,0,0));
      tab_wrap.push_back(mk(1,0,0,1,6, 0,5,0,0,1));
      tab_wrap.push_back(mk(0,1,0,0,0, 0,5,0,0,0));
      tab_wrap.push_back(mk(1,1,0,0,0, 1,0,1,1,0));
      tab_wrap.push_back(mk(0,0,1,0,0, 0,5,0,0,0));
      // Saturate mode
      tab_sat.push_back(mk(0,0,0,1,5, 0,5,0,0,0));
      tab_sat.push_back(mk(1,1,0,0,0, 1,5,1,1,0));
      tab_sat.push_back(mk(1,1,0,0,0, 1,5,1,1,0));
      tab_sat.push_back(mk(1,1,0,0,0, 1,5,1,1,0));
      tab_sat.push_back(mk(0,1,0,0,0, 0,5,0,1,0));
      tab_sat.push_back(mk(1,0,0,0,0, 0,4,0,1,0));
      tab_sat.push_back(mk(0,0,0,1,0, 0,0,0,0,0));
      tab_sat.push_back(mk(1,0,0,0,0, 1,0,1,1,0));
      tab_sat.push_back(mk(1,1,0,0,0, 0,1,0,1,0));

      #3;
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset[%0d] count", d), 32'(count_s[d]), 32'd0);
         check($sformatf("reset[%0d] ovf", d), 32'(ovf_s[d]), 32'd0);
         check($sformatf("reset[%0d] wrap", d), 32'(wrap_s[d]), 32'd0);
         check($sformatf("reset[%0d] load_err", d), 32'(lerr_s[d]), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;

      // Reset while a wrap pulse is pending, then reset from a mid-range count with ovf set.
      step(0, mk(1,0,0,0,0, 1,5,1,1,0), "pend", 0);
      mid_cycle_reset("rst_pending");
      step(0, mk(1,0,0,0,0, 1,5,1,1,0), "pre", 0);
      step(0, mk(1,0,0,0,0, 0,4,0,1,0), "pre", 1);
      step(0, mk(1,0,0,0,0, 0,3,0,1,0), "pre", 2);
      mid_cycle_reset("rst_mid");
      step(0, mk(1,1,0,0,0, 0,1,0,0,0), "post", 0);

      for (int i = 0; i < tab_wrap.size(); i++)
         step(0, tab_wrap[i], "wrap", i);
      for (int i = 0; i < tab_sat.size(); i++)
         step(1, tab_sat[i], "sat", i);

`ifdef COUNTER_MOD_PRESCALE_EN
      for (int i = 0; i < 8; i++)
         step(2, mk(1,1,0,0,0, 0,(i+1)/4,0,0,0), "pre4", i);
      step(2, mk(1,1,0,0,0, 0,2,0,0,0), "pre4_clr", 0);
      step(2, mk(0,0,0,1,0, 0,0,0,0,0), "pre4_clr", 1);
      for (int i = 0; i < 4; i++)
         step(2, mk(1,1,0,0,0, 0,(i == 3) ? 1 : 0,0,0,0), "pre4_after", i);
`endif

      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
